ps2_keyboard_s00_axi: RTL and testbench

AXI4-Lite responder (slave) register file for the PS/2 keyboard IP, answering the CPU/VIP master that issues AXI4LITE_WRITE/READ transfers. It buffers scancodes from the PS/2 receiver in a small FIFO and exposes control, status, data-pop and scratch registers. It sits between the IP's S00_AXI port and the PS/2 receiver core.

---
 rtl/ps2_keyboard_s00_axi.sv | 224 ++++++++++++++++++++++
 tb/tb_ps2_keyboard_s00_axi.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_keyboard_s00_axi.sv
// ps2_keyboard_s00_axi: AXI4-Lite register file for the PS/2 keyboard IP.
// Buffers receiver scancodes in a small FIFO and exposes CTRL (0x0),
// STATUS (0x4), DATA pop (0x8) and SCRATCH (0xC) to the CPU.
// Optional feature: define PS2KB_IRQ_EN to add CTRL.irq_en and the irq output.
module ps2_keyboard_s00_axi #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int FIFO_DEPTH         = 8
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  input  logic                            scan_valid,
  input  logic [7:0]                      scan_code
`ifdef PS2KB_IRQ_EN
  ,
  output logic                            irq
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {W_IDLE, W_ACCEPT, W_RESP} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ACCEPT, R_RESP} rd_state_t;

  wr_state_t wr_state, wr_next;
  rd_state_t rd_state, rd_next;

  logic                          ctrl_enable;
  logic                          ctrl_irq_en;
  logic                          overflow;
  logic [C_S_AXI_DATA_WIDTH-1:0] scratch;
  logic [7:0]                    mem [FIFO_DEPTH];
  logic [PTR_W-1:0]              wr_ptr, rd_ptr;
  logic [CNT_W-1:0]              count;
  logic                          empty, full;
  logic                          wr_en, rd_en, flush, ovf_clr, pop, push_req, push, drop_full;
  logic [1:0]                    wr_idx, rd_idx;
  logic [C_S_AXI_DATA_WIDTH-1:0] rd_word;

  // Protection bits and sub-word address bits carry no meaning here.
  logic unused_ok;
  assign unused_ok = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  assign S_AXI_BRESP = 2'b00;
  assign S_AXI_RRESP = 2'b00;

  // Write FSM state register
  always_ff @(posedge S_AXI_ACLK) begin
    // NOTE: sequential state always uses non-blocking assignment so every
    // flop samples pre-edge values regardless of block ordering.
    if (!S_AXI_ARESETN) wr_state <= W_IDLE;
    else                wr_state <= wr_next;
  end

  // Write FSM next state: accept only when address and data are both present
  always_comb begin
    // NOTE: default assignment first, so no path leaves wr_next unassigned
    // and no latch is inferred.
    wr_next = wr_state;
    unique case (wr_state)
      W_IDLE:   if (S_AXI_AWVALID && S_AXI_WVALID) wr_next = W_ACCEPT;
      W_ACCEPT: wr_next = W_RESP;
      W_RESP:   if (S_AXI_BREADY) wr_next = W_IDLE;
      default:  wr_next = W_IDLE;
    endcase
  end

  // Write FSM outputs decoded from state
  always_comb begin
    S_AXI_AWREADY = (wr_state == W_ACCEPT);
    S_AXI_WREADY  = (wr_state == W_ACCEPT);
    S_AXI_BVALID  = (wr_state == W_RESP);
  end

  // Read FSM state register
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) rd_state <= R_IDLE;
    else                rd_state <= rd_next;
  end

  // Read FSM next state
  always_comb begin
    rd_next = rd_state;
    unique case (rd_state)
      R_IDLE:   if (S_AXI_ARVALID) rd_next = R_ACCEPT;
      R_ACCEPT: rd_next = R_RESP;
      R_RESP:   if (S_AXI_RREADY) rd_next = R_IDLE;
      default:  rd_next = R_IDLE;
    endcase
  end

  // Read FSM outputs decoded from state
  always_comb begin
    S_AXI_ARREADY = (rd_state == R_ACCEPT);
    S_AXI_RVALID  = (rd_state == R_RESP);
  end

  // Commit strobes: the accept edge is the one where the ready is high
  assign wr_en     = (wr_state == W_ACCEPT);
  assign rd_en     = (rd_state == R_ACCEPT);
  assign wr_idx    = S_AXI_AWADDR[3:2];
  assign rd_idx    = S_AXI_ARADDR[3:2];
  assign empty     = (count == '0);
  assign full      = (count == DEPTH_CNT);
  assign flush     = wr_en && (wr_idx == 2'd0) && S_AXI_WSTRB[0] && S_AXI_WDATA[2];
  assign ovf_clr   = wr_en && (wr_idx == 2'd1) && S_AXI_WSTRB[0] && S_AXI_WDATA[2];
  assign pop       = rd_en && (rd_idx == 2'd2) && !empty;
  assign push_req  = scan_valid && ctrl_enable;
  // A pop in the same cycle frees the head slot, so a full FIFO still accepts.
  assign push      = push_req && (!full || pop);
  assign drop_full = push_req && full && !pop;

  // CTRL.enable and SCRATCH, byte-enable honoured
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      ctrl_enable <= 1'b0;
      scratch     <= '0;
    end else if (wr_en) begin
      if (wr_idx == 2'd0 && S_AXI_WSTRB[0]) ctrl_enable <= S_AXI_WDATA[0];
      if (wr_idx == 2'd3) begin
        for (int b = 0; b < C_S_AXI_DATA_WIDTH/8; b++) begin
          if (S_AXI_WSTRB[b]) scratch[b*8 +: 8] <= S_AXI_WDATA[b*8 +: 8];
        end
      end
    end
  end

`ifdef PS2KB_IRQ_EN
  // CTRL.irq_en register
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN)                               ctrl_irq_en <= 1'b0;
    else if (wr_en && wr_idx == 2'd0 && S_AXI_WSTRB[0]) ctrl_irq_en <= S_AXI_WDATA[1];
  end

  // Level interrupt, registered so it trails its cause by one cycle
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) irq <= 1'b0;
    else                irq <= ctrl_irq_en && (!empty || overflow);
  end
`else
  assign ctrl_irq_en = 1'b0;
`endif

  // Sticky overflow; a flush cycle leaves it untouched, a new drop beats a clear
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN)          overflow <= 1'b0;
    else if (drop_full && !flush) overflow <= 1'b1;
    else if (ovf_clr)             overflow <= 1'b0;
  end

  // FIFO storage
  always_ff @(posedge S_AXI_ACLK) begin
    // NOTE: the data array has no reset; only pointers and count define
    // which entries are valid, so resetting storage would add nothing.
    if (push) mem[wr_ptr] <= scan_code;
  end

  // FIFO pointers and occupancy; flush overrides any push/pop that cycle
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Read mux over pre-edge state
  always_comb begin
    rd_word = '0;
    case (rd_idx)
      2'd0: begin
        rd_word[0] = ctrl_enable;
        rd_word[1] = ctrl_irq_en;
      end
      2'd1: begin
        rd_word[0]          = empty;
        rd_word[1]          = full;
        rd_word[2]          = overflow;
        rd_word[8 +: CNT_W] = count;
      end
      2'd2: if (!empty) begin
        rd_word[31]  = 1'b1;
        rd_word[7:0] = mem[rd_ptr];
      end
      default: rd_word = scratch;
    endcase
  end

  // Read data captured on the AR accept edge, held through the response
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) S_AXI_RDATA <= '0;
    else if (rd_en)     S_AXI_RDATA <= rd_word;
  end

endmodule

// File: tb/tb_ps2_keyboard_s00_axi.sv
// Self-checking bench for ps2_keyboard_s00_axi: directed steps plus a random
// stream, checked against a queue-based model of the register map.
module tb_ps2_keyboard_s00_axi;

  localparam int DEPTH = 8;

  logic        S_AXI_ACLK = 1'b0;
  logic        S_AXI_ARESETN;
  logic [3:0]  S_AXI_AWADDR;
  logic [2:0]  S_AXI_AWPROT;
  logic        S_AXI_AWVALID;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_WVALID;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY;
  logic [3:0]  S_AXI_ARADDR;
  logic [2:0]  S_AXI_ARPROT;
  logic        S_AXI_ARVALID;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY;
  logic        scan_valid;
  logic [7:0]  scan_code;
`ifdef PS2KB_IRQ_EN
  logic        irq;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0]  q[$];
  bit          m_enable;
  bit          m_irq_en;
  bit          m_ovf;
  logic [31:0] m_scratch;

  ps2_keyboard_s00_axi #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4), .FIFO_DEPTH(DEPTH)) dut (
    .S_AXI_ACLK(S_AXI_ACLK), .S_AXI_ARESETN(S_AXI_ARESETN),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .scan_valid(scan_valid), .scan_code(scan_code)
`ifdef PS2KB_IRQ_EN
    , .irq(irq)
`endif
  );

  always #5 S_AXI_ACLK = ~S_AXI_ACLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Model: register value a read of word idx would return now (no side effect)
  function automatic logic [31:0] model_read(input logic [1:0] idx);
    logic [31:0] r;
    r = '0;
    case (idx)
      2'd0: begin
        r[0] = m_enable;
`ifdef PS2KB_IRQ_EN
        r[1] = m_irq_en;
`endif
      end
      2'd1: begin
        r[0]    = (q.size() == 0);
        r[1]    = (q.size() == DEPTH);
        r[2]    = m_ovf;
        r[11:8] = 4'(q.size());
      end
      2'd2: if (q.size() > 0) r = {1'b1, 23'b0, q[0]};
      default: r = m_scratch;
    endcase
    return r;
  endfunction

  function automatic void model_push(input logic [7:0] code);
    if (m_enable) begin
      if (q.size() < DEPTH) q.push_back(code);
      else                  m_ovf = 1'b1;
    end
  endfunction

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int bdelay);
    int n;
    @(negedge S_AXI_ACLK);
    S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = strb;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    n = 0;
    while (!S_AXI_AWREADY && n < 20) begin
      @(negedge S_AXI_ACLK);
      n++;
    end
    check("aw_w_ready", {31'b0, S_AXI_AWREADY & S_AXI_WREADY}, 32'd1);
    @(posedge S_AXI_ACLK);
    #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    check("bvalid_latency", {31'b0, S_AXI_BVALID}, 32'd1);
    check("bresp", {30'b0, S_AXI_BRESP}, 32'd0);
    for (int i = 0; i < bdelay; i++) begin
      @(negedge S_AXI_ACLK);
      check("bvalid_hold", {29'b0, S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY}, 32'h4);
    end
    @(negedge S_AXI_ACLK);
    S_AXI_BREADY = 1'b1;
    @(posedge S_AXI_ACLK);
    #1 S_AXI_BREADY = 1'b0;
    check("bvalid_clear", {31'b0, S_AXI_BVALID}, 32'd0);
  endtask

  task automatic axi_read(input logic [3:0] addr, input bit push_en, input logic [7:0] code,
                          output logic [31:0] data);
    int n;
    @(negedge S_AXI_ACLK);
    S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1;
    n = 0;
    while (!S_AXI_ARREADY && n < 20) begin
      @(negedge S_AXI_ACLK);
      n++;
    end
    check("ar_ready", {31'b0, S_AXI_ARREADY}, 32'd1);
    if (push_en) begin
      scan_valid = 1'b1;
      scan_code  = code;
    end
    @(posedge S_AXI_ACLK);
    #1;
    S_AXI_ARVALID = 1'b0; scan_valid = 1'b0;
    check("rvalid_latency", {31'b0, S_AXI_RVALID}, 32'd1);
    check("rresp", {30'b0, S_AXI_RRESP}, 32'd0);
    data = S_AXI_RDATA;
    @(negedge S_AXI_ACLK);
    S_AXI_RREADY = 1'b1;
    @(posedge S_AXI_ACLK);
    #1 S_AXI_RREADY = 1'b0;
  endtask

  task automatic do_write(input logic [3:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int bdelay);
    axi_write(addr, data, strb, bdelay);
    case (addr[3:2])
      2'd0: if (strb[0]) begin
        m_enable = data[0];
        m_irq_en = data[1];
        if (data[2]) q.delete();
      end
      2'd1: if (strb[0] && data[2]) m_ovf = 1'b0;
      2'd3: for (int b = 0; b < 4; b++) if (strb[b]) m_scratch[b*8 +: 8] = data[b*8 +: 8];
      default: ;
    endcase
  endtask

  task automatic do_read(input string tag, input logic [3:0] addr,
                         input bit push_en, input logic [7:0] code);
    logic [31:0] exp, got;
    exp = model_read(addr[3:2]);
    if (addr[3:2] == 2'd2 && q.size() > 0) void'(q.pop_front());
    axi_read(addr, push_en, code, got);
    if (push_en) model_push(code);
    check(tag, got, exp);
  endtask

  task automatic do_push(input logic [7:0] code);
    @(negedge S_AXI_ACLK);
    scan_valid = 1'b1; scan_code = code;
    @(posedge S_AXI_ACLK);
    #1 scan_valid = 1'b0;
    model_push(code);
  endtask

  initial begin
    logic [7:0] first_code;
    S_AXI_ARESETN = 1'b0;
    S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
    S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
    scan_valid = 1'b0; scan_code = '0;
    m_enable = 0; m_irq_en = 0; m_ovf = 0; m_scratch = '0;

    // Reset state
    repeat (3) @(posedge S_AXI_ACLK);
    @(negedge S_AXI_ACLK);
    check("reset_ready_valid", {27'b0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID,
                                S_AXI_ARREADY, S_AXI_RVALID}, 32'd0);
    check("reset_rdata", S_AXI_RDATA, 32'd0);
    check("reset_resp", {28'b0, S_AXI_BRESP, S_AXI_RRESP}, 32'd0);
    S_AXI_ARESETN = 1'b1;

    // AW without W must not be accepted
    @(negedge S_AXI_ACLK);
    S_AXI_AWVALID = 1'b1; S_AXI_AWADDR = 4'hC;
    repeat (3) begin
      @(negedge S_AXI_ACLK);
      check("aw_only_waits", {30'b0, S_AXI_AWREADY, S_AXI_BVALID}, 32'd0);
    end
    S_AXI_AWVALID = 1'b0;

    // Basic map write/readback
    do_write(4'h0, 32'h1, 4'hF, 0);
    do_write(4'h4, 32'h2, 4'hF, 0);
    do_write(4'h8, 32'h3, 4'hF, 0);
    do_write(4'hC, 32'h4, 4'hF, 0);
    do_read("ctrl_basic", 4'h0, 0, 8'h00);
    do_read("status_empty", 4'h4, 0, 8'h00);
    do_read("data_empty", 4'h8, 0, 8'h00);
    do_read("scratch_basic", 4'hC, 0, 8'h00);

    // Three pushes and pops
    do_push(8'h1C); do_push(8'hF0); do_push(8'h1C);
    do_read("status_count3", 4'h4, 0, 8'h00);
    for (int i = 0; i < 4; i++) do_read("data_pop", 4'h8, 0, 8'h00);
    do_read("status_drained", 4'h4, 0, 8'h00);

    // Overflow with random codes, W1C, first pop
    for (int i = 0; i < DEPTH + 1; i++) do_push(8'($urandom_range(0, 255)));
    first_code = q[0];
    do_read("status_overflow", 4'h4, 0, 8'h00);
    do_write(4'h4, 32'h4, 4'hF, 0);
    do_read("status_ovf_cleared", 4'h4, 0, 8'h00);
    do_read("data_first_after_ovf", 4'h8, 0, 8'h00);
    check("first_code_kept", {24'b0, first_code}, {24'b0, q.size() == DEPTH - 1 ? first_code : 8'hXX});

    // Full FIFO with push on the pop edge
    do_push(8'($urandom_range(0, 255)));
    do_read("data_pop_push_full", 4'h8, 1, 8'h5A);
    do_read("status_full_no_ovf", 4'h4, 0, 8'h00);

    // Overflow, then flush racing a DATA read
    do_push(8'h77);
    fork
      do_write(4'h0, 32'h7, 4'hF, 0);
      do_read("data_pre_flush", 4'h8, 0, 8'h00);
    join
    do_read("status_after_flush", 4'h4, 0, 8'h00);
    do_read("ctrl_after_flush", 4'h0, 0, 8'h00);

    // Disabled FIFO drops silently; W1C needs WSTRB[0]
    do_write(4'h0, 32'h0, 4'hF, 0);
    do_push(8'h12);
    do_read("status_disabled_drop", 4'h4, 0, 8'h00);
    do_write(4'h4, 32'h4, 4'hE, 0);
    do_read("status_w1c_nostrb", 4'h4, 0, 8'h00);
    do_write(4'h4, 32'h4, 4'h1, 0);
    do_read("status_w1c_strb", 4'h4, 0, 8'h00);

    // SCRATCH byte enables, with a slow BREADY
    do_write(4'hC, 32'h0, 4'hF, 0);
    do_write(4'hC, 32'hAABBCCDD, 4'b0010, 5);
    do_read("scratch_strb", 4'hC, 0, 8'h00);
    for (int i = 0; i < 6; i++) begin
      do_write(4'hC, $urandom, 4'($urandom_range(0, 15)), 0);
      do_read("scratch_rand", 4'hC, 0, 8'h00);
    end

    // Random stream of pushes, pops and status reads
    do_write(4'h0, 32'h1, 4'hF, 0);
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 3))
        0, 1:    do_push(8'($urandom_range(0, 255)));
        2:       do_read("rand_data", 4'h8, 0, 8'h00);
        default: do_read("rand_status", 4'h4, 0, 8'h00);
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
